// File: rtl/encoder_decoder_mul_arb.sv
// Round-robin arbiter feeding one shared 13x10 signed multiplier pipeline.
// Each accepted operand pair is tagged with its requester and its product is returned to that requester.
module encoder_decoder_mul_arb #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned A_WIDTH   = 13,
    parameter int unsigned B_WIDTH   = 10,
    parameter int unsigned P_WIDTH   = 23,
    parameter int unsigned NUM_STAGE = 2,
    parameter int unsigned ID_WIDTH  = 2
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         en,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [P_WIDTH-1:0]           rsp_p,
    output logic [ID_WIDTH-1:0]          rsp_id,
    output logic                         idle
);

    localparam int unsigned LAST_ID = NUM_REQ - 1;

    logic [ID_WIDTH-1:0] ptr;
    logic [ID_WIDTH-1:0] gnt_id;
    logic [ID_WIDTH-1:0] scan_id;
    logic                hs;

    logic                op_valid;
    logic [A_WIDTH-1:0]  op_a;
    logic [B_WIDTH-1:0]  op_b;
    logic [ID_WIDTH-1:0] op_id;

    logic signed [P_WIDTH-1:0] prod;

    logic                tail_valid;
    logic [P_WIDTH-1:0]  tail_p;
    logic [ID_WIDTH-1:0] tail_id;
    logic                mid_busy;

    // First asserted request scanning from ptr wins; grant is purely combinational.
    always_comb begin
        req_ready = '0;
        gnt_id    = '0;
        hs        = 1'b0;
        scan_id   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_id = ID_WIDTH'((32'(ptr) + k) % NUM_REQ);
            if (ap_rst_n && en && !hs && req_valid[scan_id]) begin
                req_ready[scan_id] = 1'b1;
                gnt_id             = scan_id;
                hs                 = 1'b1;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ptr <= '0;
        end else if (hs) begin
            ptr <= (gnt_id == ID_WIDTH'(LAST_ID)) ? '0 : gnt_id + ID_WIDTH'(1);
        end
    end

    // Operand register: one entry per handshake, bubble otherwise.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_id    <= '0;
        end else begin
            op_valid <= hs;
            if (hs) begin
                op_a  <= req_a[32'(gnt_id) * A_WIDTH +: A_WIDTH];
                op_b  <= req_b[32'(gnt_id) * B_WIDTH +: B_WIDTH];
                op_id <= gnt_id;
            end
        end
    end

    // a is unsigned, so a zero MSB is prepended before the signed multiply.
    assign prod = P_WIDTH'($signed({1'b0, op_a})) * P_WIDTH'($signed(op_b));

    // Intermediate stages; the final stage is the registered response itself.
    if (NUM_STAGE > 1) begin : g_mid
        localparam int unsigned MID = NUM_STAGE - 1;

        logic [MID-1:0]      v;
        logic [P_WIDTH-1:0]  p  [MID];
        logic [ID_WIDTH-1:0] id [MID];

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                v <= '0;
                for (int unsigned i = 0; i < MID; i++) begin
                    p[i]  <= '0;
                    id[i] <= '0;
                end
            end else begin
                v[0]  <= op_valid;
                p[0]  <= prod;
                id[0] <= op_id;
                for (int unsigned i = 1; i < MID; i++) begin
                    v[i]  <= v[i-1];
                    p[i]  <= p[i-1];
                    id[i] <= id[i-1];
                end
            end
        end

        assign tail_valid = v[MID-1];
        assign tail_p     = p[MID-1];
        assign tail_id    = id[MID-1];
        assign mid_busy   = |v;
    end else begin : g_nomid
        assign tail_valid = op_valid;
        assign tail_p     = prod;
        assign tail_id    = op_id;
        assign mid_busy   = 1'b0;
    end

    // idle is registered from the next-cycle occupancy of every stage.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rsp_valid <= '0;
            rsp_p     <= '0;
            rsp_id    <= '0;
            idle      <= 1'b1;
        end else begin
            rsp_valid <= tail_valid ? (NUM_REQ'(1) << tail_id) : '0;
            if (tail_valid) begin
                rsp_p  <= tail_p;
                rsp_id <= tail_id;
            end
            idle <= ~(hs | op_valid | mid_busy);
        end
    end

endmodule

// File: tb/tb_encoder_decoder_mul_arb.sv
// Bench for encoder_decoder_mul_arb: directed scenarios plus random traffic against a
// queue-based model of grant rotation, product arithmetic and fixed response latency.
module tb_encoder_decoder_mul_arb;

    localparam int N   = 4;
    localparam int LAT = 3;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic          en;
    logic [N-1:0]  req_valid;
    logic [51:0]   req_a;
    logic [39:0]   req_b;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  rsp_valid;
    logic [22:0]   rsp_p;
    logic [1:0]    rsp_id;
    logic          idle;

    logic [12:0]        ta  [N];
    logic signed [9:0]  tbv [N];

    typedef struct {
        int          due;
        int          id;
        logic [22:0] p;
    } exp_t;
    exp_t q[$];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int mptr   = 0;

    logic [N-1:0] exp_ready, obs_ready, exp_rv, obs_rv;
    logic [22:0]  exp_p, obs_p, last_p;
    logic [1:0]   exp_id, obs_id, last_id;
    logic         exp_idle, obs_idle;

    encoder_decoder_mul_arb dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_p     (rsp_p),
        .rsp_id    (rsp_id),
        .idle      (idle)
    );

    always #5 ap_clk = ~ap_clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_a[i*13 +: 13] = ta[i];
            req_b[i*10 +: 10] = tbv[i];
        end
    end

    // Reference model: sample the DUT mid-cycle, predict this cycle, then advance one clock.
    task automatic tick();
        exp_t e;
        int   j;
        @(negedge ap_clk);
        obs_ready = req_ready;
        obs_rv    = rsp_valid;
        obs_p     = rsp_p;
        obs_id    = rsp_id;
        obs_idle  = idle;
        exp_ready = '0;
        exp_rv    = '0;
        if (!ap_rst_n) begin
            q.delete();
            mptr     = 0;
            last_p   = '0;
            last_id  = '0;
            exp_idle = 1'b1;
        end else begin
            exp_idle = (q.size() == 0);
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_rv  = N'(1) << q[0].id;
                last_p  = q[0].p;
                last_id = 2'(q[0].id);
                void'(q.pop_front());
            end
            if (en) begin
                for (int k = 0; k < N; k++) begin
                    j = (mptr + k) % N;
                    if (exp_ready == '0 && req_valid[j]) begin
                        exp_ready[j] = 1'b1;
                        e.due = cyc + LAT;
                        e.id  = j;
                        e.p   = 23'(int'(ta[j]) * int'(tbv[j]));
                        q.push_back(e);
                        mptr = (j + 1) % N;
                    end
                end
            end
        end
        exp_p  = last_p;
        exp_id = last_id;
        @(posedge ap_clk);
        #1;
        cyc++;
    endtask

    // Give each granted requester fresh operands; ungranted requesters keep theirs stable.
    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            if (exp_ready[i]) begin
                ta[i]  = 13'($urandom);
                tbv[i] = 10'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        ap_rst_n  = 1'b0;
        en        = 1'b1;
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            ta[i]  = '0;
            tbv[i] = '0;
        end
        for (int c = 0; c < 3; c++) begin
            if (c == 2) req_valid = 4'b1111;
            tick();
            checks++; if (obs_ready !== 4'b0000) begin errors++; $display("FAIL reset req_ready: got %b expected 0000", obs_ready); end
            checks++; if (obs_rv !== 4'b0000) begin errors++; $display("FAIL reset rsp_valid: got %b expected 0000", obs_rv); end
            checks++; if (obs_p !== 23'd0 || obs_id !== 2'd0) begin errors++; $display("FAIL reset rsp_p/rsp_id: got %0h/%0d expected 0/0", obs_p, obs_id); end
            checks++; if (obs_idle !== 1'b1) begin errors++; $display("FAIL reset idle: got %b expected 1", obs_idle); end
        end
        req_valid = '0;
        ap_rst_n  = 1'b1;
    endtask

    task automatic test_single();
        logic [22:0] want_p;
        want_p    = 23'(-300);
        req_valid = 4'b0100;
        ta[2]     = 13'd100;
        tbv[2]    = -10'sd3;
        for (int c = 0; c < 5; c++) begin
            tick();
            req_valid = '0;
            checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL single req_ready c%0d: got %b expected %b", c, obs_ready, exp_ready); end
            checks++; if (obs_rv !== exp_rv) begin errors++; $display("FAIL single rsp_valid c%0d: got %b expected %b", c, obs_rv, exp_rv); end
            checks++; if (obs_idle !== exp_idle) begin errors++; $display("FAIL single idle c%0d: got %b expected %b", c, obs_idle, exp_idle); end
            if (c == 0) begin
                checks++; if (obs_ready !== 4'b0100) begin errors++; $display("FAIL single grant: got %b expected 0100", obs_ready); end
            end
            if (c == 3) begin
                checks++;
                if (obs_rv !== 4'b0100 || obs_p !== want_p || obs_id !== 2'd2) begin
                    errors++; $display("FAIL single result: got %b/%0d/%0d expected 0100/-300/2", obs_rv, $signed(obs_p), obs_id);
                end
            end
            if (c == 4) begin
                checks++; if (obs_idle !== 1'b1) begin errors++; $display("FAIL single idle_after: got %b expected 1", obs_idle); end
            end
        end
    endtask

    task automatic test_extremes();
        logic [12:0]       av   [3];
        logic signed [9:0] bv   [3];
        logic [22:0]       want [3];
        av[0] = 13'd8191; bv[0] = -10'sd512; want[0] = 23'(-4193792);
        av[1] = 13'd8191; bv[1] = 10'sd511;  want[1] = 23'(4185601);
        av[2] = 13'd0;    bv[2] = -10'sd1;   want[2] = 23'd0;
        for (int c = 0; c < 8; c++) begin
            if (c < 3) begin
                req_valid = 4'b0001;
                ta[0]     = av[c];
                tbv[0]    = bv[c];
            end else begin
                req_valid = '0;
            end
            tick();
            checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL extremes req_ready c%0d: got %b expected %b", c, obs_ready, exp_ready); end
            checks++; if (obs_rv !== exp_rv || obs_p !== exp_p) begin errors++; $display("FAIL extremes rsp c%0d: got %b/%0d expected %b/%0d", c, obs_rv, $signed(obs_p), exp_rv, $signed(exp_p)); end
            if (c >= 3 && c <= 5) begin
                checks++; if (obs_p !== want[c-3]) begin errors++; $display("FAIL extremes product %0d: got %0d expected %0d", c - 3, $signed(obs_p), $signed(want[c-3])); end
            end
        end
    endtask

    task automatic test_fairness();
        for (int i = 0; i < N; i++) begin
            ta[i]  = 13'($urandom);
            tbv[i] = 10'($urandom);
        end
        for (int c = 0; c < 13; c++) begin
            req_valid = (c < 8) ? 4'b1111 : 4'b0000;
            tick();
            refresh();
            checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL fairness req_ready c%0d: got %b expected %b", c, obs_ready, exp_ready); end
            checks++; if (obs_rv !== exp_rv) begin errors++; $display("FAIL fairness rsp_valid c%0d: got %b expected %b", c, obs_rv, exp_rv); end
            checks++; if (obs_p !== exp_p || obs_id !== exp_id) begin errors++; $display("FAIL fairness rsp_p/id c%0d: got %0d/%0d expected %0d/%0d", c, $signed(obs_p), obs_id, $signed(exp_p), exp_id); end
        end
    endtask

    task automatic test_ptr_resume();
        logic [N-1:0] pat [3];
        logic [N-1:0] grant [3];
        pat[0] = 4'b0010; grant[0] = 4'b0010;
        pat[1] = 4'b1001; grant[1] = 4'b1000;
        pat[2] = 4'b0001; grant[2] = 4'b0001;
        for (int c = 0; c < 7; c++) begin
            req_valid = (c < 3) ? pat[c] : 4'b0000;
            tick();
            refresh();
            checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL ptr_resume req_ready c%0d: got %b expected %b", c, obs_ready, exp_ready); end
            checks++; if (obs_rv !== exp_rv || obs_id !== exp_id) begin errors++; $display("FAIL ptr_resume rsp c%0d: got %b/%0d expected %b/%0d", c, obs_rv, obs_id, exp_rv, exp_id); end
            if (c < 3) begin
                checks++; if (obs_ready !== grant[c]) begin errors++; $display("FAIL ptr_resume order c%0d: got %b expected %b", c, obs_ready, grant[c]); end
            end
        end
    endtask

    task automatic test_en_gating();
        for (int c = 0; c < 13; c++) begin
            req_valid = (c < 9) ? 4'b1111 : 4'b0000;
            en        = (c == 3 || c == 4) ? 1'b0 : 1'b1;
            tick();
            refresh();
            checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL en_gating req_ready c%0d: got %b expected %b", c, obs_ready, exp_ready); end
            checks++; if (obs_rv !== exp_rv || obs_p !== exp_p) begin errors++; $display("FAIL en_gating rsp c%0d: got %b/%0d expected %b/%0d", c, obs_rv, $signed(obs_p), exp_rv, $signed(exp_p)); end
            checks++; if (obs_idle !== exp_idle) begin errors++; $display("FAIL en_gating idle c%0d: got %b expected %b", c, obs_idle, exp_idle); end
            if (!en) begin
                checks++; if (obs_ready !== 4'b0000) begin errors++; $display("FAIL en_gating blocked c%0d: got %b expected 0000", c, obs_ready); end
            end
        end
        en = 1'b1;
    endtask

    task automatic test_reset_midflight();
        req_valid = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            tick();
            refresh();
        end
        ap_rst_n = 1'b0;
        tick();
        ap_rst_n  = 1'b1;
        req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (obs_rv !== 4'b0000) begin errors++; $display("FAIL midflight rsp_valid c%0d: got %b expected 0000", c, obs_rv); end
            checks++; if (obs_idle !== 1'b1) begin errors++; $display("FAIL midflight idle c%0d: got %b expected 1", c, obs_idle); end
        end
        req_valid = 4'b1111;
        tick();
        refresh();
        checks++; if (obs_ready !== 4'b0001) begin errors++; $display("FAIL midflight ptr: got %b expected 0001", obs_ready); end
        req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (obs_rv !== exp_rv || obs_p !== exp_p || obs_id !== exp_id) begin errors++; $display("FAIL midflight drain c%0d: got %b/%0d/%0d expected %b/%0d/%0d", c, obs_rv, $signed(obs_p), obs_id, exp_rv, $signed(exp_p), exp_id); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            en = ($urandom_range(0, 9) != 0);
            tick();
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || exp_ready[i]) begin
                    req_valid[i] = ($urandom_range(0, 9) < 6);
                    ta[i]        = 13'($urandom);
                    tbv[i]       = 10'($urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL random req_ready c%0d: got %b expected %b", c, obs_ready, exp_ready); end
            checks++; if (obs_rv !== exp_rv) begin errors++; $display("FAIL random rsp_valid c%0d: got %b expected %b", c, obs_rv, exp_rv); end
            checks++; if (obs_p !== exp_p || obs_id !== exp_id) begin errors++; $display("FAIL random rsp_p/id c%0d: got %0d/%0d expected %0d/%0d", c, $signed(obs_p), obs_id, $signed(exp_p), exp_id); end
            checks++; if (obs_idle !== exp_idle) begin errors++; $display("FAIL random idle c%0d: got %b expected %b", c, obs_idle, exp_idle); end
        end
        en        = 1'b1;
        req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (obs_rv !== exp_rv || obs_idle !== exp_idle) begin errors++; $display("FAIL random drain c%0d: got %b/%b expected %b/%b", c, obs_rv, obs_idle, exp_rv, exp_idle); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_extremes();
        test_fairness();
        test_ptr_resume();
        test_en_gating();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/encoder_decoder_mul_arb.md
# encoder_decoder_mul_arb

Round-robin arbiter and pipeline sequencer that time-shares one 13-bit-unsigned × 10-bit-signed DSP multiplier among several encoder/decoder requesters. It accepts one operand pair per cycle through a valid/ready handshake and tags each pair with its requester index. The pair flows through a fixed-depth product pipeline, and the 23-bit signed product is returned to the originating requester. The block sits between the layer MAC engines and the shared multiplier datapath.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- A_WIDTH, 13, operand a width, unsigned
- B_WIDTH, 10, operand b width, two's complement
- P_WIDTH, 23, product width (= A_WIDTH + B_WIDTH)
- NUM_STAGE, 2, multiplier pipeline stages after the operand register (≥1)
- ID_WIDTH, 2, requester tag width (= clog2(NUM_REQ), min 1)

Ports:
- ap_clk  in  1  clock, all state on rising edge
- ap_rst_n  in  1  asynchronous, active-low reset
- en  in  1  grant enable; 0 blocks new grants, in-flight work drains
- req_valid  in  NUM_REQ  per-requester request
- req_a  in  NUM_REQ*A_WIDTH  packed operand a, requester i at [i*A_WIDTH +: A_WIDTH]
- req_b  in  NUM_REQ*B_WIDTH  packed operand b, same packing
- req_ready  out  NUM_REQ  one-hot-or-zero grant
- rsp_valid  out  NUM_REQ  one-hot-or-zero result strobe, indexed by originating requester
- rsp_p  out  P_WIDTH  signed product
- rsp_id  out  ID_WIDTH  originating requester index
- idle  out  1  high when no valid entry is in the operand register or any pipeline stage

## Operation
- Arbitration: the priority pointer ptr resets to 0.
  - req_ready[i] = ap_rst_n & en & req_valid[i] & (i is the first asserted valid scanning ptr, ptr+1, … mod NUM_REQ).
  - A handshake is req_valid[i] & req_ready[i].
  - After a handshake with i, ptr ← (i+1) mod NUM_REQ. Without a handshake, ptr holds.
- Requesters hold valid, a and b stable until the handshake. Dropping valid before the handshake is allowed and simply withdraws the request.
- On a handshake, the operand register captures a, b, the tag i and valid=1. With no handshake it captures valid=0.
- Product: p = signed({1'b0,a}) × signed(b), exact at 23 bits with no saturation or rounding.
  - Range: −4,193,792 (8191 × −512) to 4,185,601 (8191 × 511).
- The pipeline carries valid and tag alongside the data. Every stage advances every cycle; there is no backpressure on the response side.
- Output stage: rsp_valid = onehot(tag) when the last-stage valid is 1, else 0. rsp_p and rsp_id hold their last values while rsp_valid = 0.
- en = 0: req_ready goes all-zero that cycle. In-flight entries still complete, and ptr holds.
- idle = ~(any stage valid).

## Timing
- Throughput: one handshake per cycle, sustained, across any mix of requesters.
- Latency: a handshake in cycle t produces rsp_valid in cycle t + NUM_STAGE + 1 (t+3 at the default). rsp_p and rsp_id are valid in the same cycle.
- Results return in acceptance order; the tag is the only identification.
- req_ready is combinational from req_valid, en and ptr. It has no dependency on the response side.
- Reset (asynchronous assert, synchronous release):
  - ptr=0, all stage valids=0, rsp_valid=0, rsp_p=0, rsp_id=0, idle=1.
  - req_ready=0 while ap_rst_n=0.
- Reset mid-operation discards all in-flight entries. No rsp_valid is produced for them after release.
- Simultaneous requests: exactly one grant per cycle. A continuously requesting set is served in strict rotation, and no requester waits more than NUM_REQ−1 grants.
- Single requester asserting continuously: granted every cycle, whatever the ptr position.
- en deasserted in the same cycle a requester raises valid: no grant. The grant occurs on the first cycle with en=1.

## Test plan
- Reset and single request: hold ap_rst_n=0, then release. Check all outputs at reset values and idle=1. Requester 2 issues a=100, b=−3 at cycle t. Expect req_ready=0100 at t, rsp_valid=0100, rsp_p=−300, rsp_id=2 at t+3, and idle=1 at t+4.
- Extremes: a=8191,b=−512 → rsp_p=−4193792. a=8191,b=511 → 4185601. a=0,b=−1 → 0.
- Fairness: all four valid for 8 cycles. Expect grant order 0,1,2,3,0,1,2,3 and responses with rsp_id 0,1,2,3,0,1,2,3 on consecutive cycles starting 3 cycles later.
- Pointer resume: grant requester 1, then only requesters 0 and 3 valid. Expect grant 3, then 0.
- en gating: all valid, en dropped for 2 cycles mid-stream. Expect no req_ready during those cycles, previously accepted results still emerge, and rotation resumes from the held ptr.
- Reset mid-flight: 3 entries in flight, pulse ap_rst_n low for one cycle. Expect no rsp_valid afterwards, ptr=0 and idle=1.
